paddle_ai: RTL and testbench
============================

Name: paddle_ai

Overview:
- Computer opponent. Produces `up`/`down` paddle commands in the same form as the button-derived commands the game core consumes (p2_up/p2_down).
- Watches ball position and direction plus its own paddle position, and steers the paddle with a limited reaction rate.
- Sits beside the movement core. Its outputs are muxed with the physical player controls at top level.

Parameters:
- SIDE, 1, paddle side: 1 = right paddle, 0 = left paddle.
- PADDLE_H, 40, paddle height in pixels; paddle_y is the top edge.
- SCREEN_H, 480, playfield height in pixels.
- CENTER_Y, 240, rest target while the ball recedes.
- DEADZONE, 4, no-move band half-width in pixels.
- REACT_CYCLES, 16, clocks between decisions; must be ≥ 2.
- MISS_THRESH, 8'd32, miss probability numerator out of 256 (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  AI owns the paddle when high
- ball_y  in  10  ball centre Y
- ball_direction  in  2  bit0 horizontal (1 = moving right), bit1 vertical
- paddle_y  in  10  current top of the controlled paddle
- up  out  1  move paddle up (toward y = 0), registered
- down  out  1  move paddle down, registered
- state  out  2  FSM state, for debug
- decide  out  1  one-cycle pulse on each decision edge

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE (2'd0), up = 0, down = 0, decide = 0.
  - Divider count = 0, LFSR = 8'h01.
- Divider:
  - Counts 0..REACT_CYCLES-1 while enable = 1, then wraps to 0.
  - Strobe asserts when count == REACT_CYCLES-1.
  - `decide` is the registered strobe: high the cycle after the strobe, for exactly one cycle.
- Approach flag: approaching = (ball_direction[0] == SIDE).
- States: IDLE = 0, TRACK = 1, RETURN = 2. Value 3 is unused and recovers to IDLE on the next clock.
- Transitions:
  - enable = 0 in any state: next clock goes to IDLE; up = down = 0; count cleared. This takes priority over everything else.
  - IDLE with enable = 1: go to TRACK if approaching, else RETURN. The transition is taken at the first strobe.
  - TRACK / RETURN: re-evaluated at every strobe and set from the approaching flag. Between strobes the state holds.
- Decision at strobe, all arithmetic unsigned-extended to 12 bits, signed compare:
  - target = (next state == TRACK) ? ball_y : CENTER_Y.
  - centre = paddle_y + PADDLE_H/2.
  - diff = target − centre.
  - diff > DEADZONE → down = 1, up = 0.
  - diff < −DEADZONE → up = 1, down = 0.
  - Otherwise (including diff = ±DEADZONE exactly) → both 0.
- Edge clamps, applied after the decision:
  - paddle_y == 0 → up forced to 0.
  - paddle_y ≥ SCREEN_H − PADDLE_H → down forced to 0.
- Output hold and latency:
  - up/down are updated only on the strobe edge and held constant between strobes.
  - up and down are never both 1.
  - Latency from an input change to an output response is ≤ REACT_CYCLES+1 clocks.
- Simultaneous events:
  - enable falling on a strobe cycle → IDLE wins; outputs go to 0.
  - reset asserted mid-window → full reset state next clock.

Optional Feature:
- Macro: PADDLE_AI_MISS_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8, 6, 5, 4; seed 8'h01) advances once per strobe.
  - If the pre-advance LFSR value < MISS_THRESH, the decision for that window is forced to up = down = 0. This applies in TRACK only; RETURN is not affected.
  - The LFSR never reaches 0.
- Undefined: no LFSR, MISS_THRESH ignored, decisions are always taken as computed.

Test Plan:
- Reset held 3 clocks, then released with enable = 0 → up = down = 0, state = 0, decide never pulses over 100 clocks.
- enable = 1, SIDE = 1, ball_direction = 2'b01, ball_y = 300, paddle_y = 100 (centre 120):
  - First decide pulse at clock 16 after enable.
  - state = TRACK, down = 1, up = 0, held for 16 clocks.
- Same setup, ball_y = 124 (diff = +4), then 125 → down = 0 for diff = 4; down = 1 at the next strobe after ball_y = 125.
- ball_direction = 2'b00 (receding), paddle_y = 0, ball_y = 0:
  - state = RETURN; target 240 vs centre 20 → down = 1.
  - Then paddle_y = 0 with target above the centre → up stays 0 (clamp).
- paddle_y = 440, TRACK, ball_y = 479 → down = 0 (bottom clamp).
- enable dropped on the exact strobe cycle while down = 1 → next clock state = IDLE, down = 0, no decide pulse.
- With PADDLE_AI_MISS_EN and MISS_THRESH = 8'd2: from the 8'h01 seed, the first TRACK decision is suppressed (outputs 0); the second follows the computed direction.

Source files
------------

// File: rtl/paddle_ai.sv
// Computer-controlled paddle: steers toward the ball (or screen centre) once per reaction window.
// Optional macro PADDLE_AI_MISS_EN adds an LFSR that randomly skips tracking decisions.
module paddle_ai #(
    parameter bit         SIDE         = 1'b1,
    parameter int         PADDLE_H     = 40,
    parameter int         SCREEN_H     = 480,
    parameter int         CENTER_Y     = 240,
    parameter int         DEADZONE     = 4,
    parameter int         REACT_CYCLES = 16,
    parameter logic [7:0] MISS_THRESH  = 8'd32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] ball_y,
    input  logic [1:0] ball_direction,
    input  logic [9:0] paddle_y,
    output logic       up,
    output logic       down,
    output logic [1:0] state,
    output logic       decide
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        RETURN = 2'd2,
        UNUSED = 2'd3
    } state_t;

    localparam int                CNT_W    = (REACT_CYCLES > 1) ? $clog2(REACT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REACT_CYCLES - 1);
    localparam logic signed [11:0] DZ_POS  = 12'(DEADZONE);
    localparam logic signed [11:0] DZ_NEG  = 12'(-DEADZONE);
    localparam logic [11:0]       HALF_H   = 12'(PADDLE_H / 2);
    localparam logic [11:0]       CENTER_T = 12'(CENTER_Y);
    localparam logic [9:0]        BOTTOM_Y = 10'(SCREEN_H - PADDLE_H);

    state_t            state_q, state_d, dec_state;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              up_q, up_d;
    logic              down_q, down_d;
    logic              decide_q, decide_d;
    logic              strobe;
    logic              approaching;
    logic              miss;
    logic              want_up, want_down;
    logic [11:0]       target, centre;
    logic signed [11:0] diff;

    assign strobe = enable && (count_q == CNT_LAST);

    always_comb begin
        approaching = (ball_direction[0] == SIDE);
        dec_state   = approaching ? TRACK : RETURN;
        target      = (dec_state == TRACK) ? {2'b00, ball_y} : CENTER_T;
        centre      = {2'b00, paddle_y} + HALF_H;
        diff        = target - centre;
        // Clamps stop the paddle from being pushed past either screen edge.
        want_down   = (diff > DZ_POS) && (paddle_y < BOTTOM_Y);
        want_up     = (diff < DZ_NEG) && (paddle_y != 10'd0);
    end

`ifdef PADDLE_AI_MISS_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (strobe) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
        miss = (dec_state == TRACK) && (lfsr_q < MISS_THRESH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic unused_miss_thresh;
    assign unused_miss_thresh = ^MISS_THRESH;
    assign miss = 1'b0;
`endif

    logic unused_vertical_dir;
    assign unused_vertical_dir = ball_direction[1];

    always_comb begin
        count_d  = count_q;
        state_d  = state_q;
        up_d     = up_q;
        down_d   = down_q;
        decide_d = strobe;

        if (!enable || strobe) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end

        // Losing enable (or landing in the spare encoding) overrides any decision.
        if (!enable || state_q == UNUSED) begin
            state_d = IDLE;
            up_d    = 1'b0;
            down_d  = 1'b0;
        end else if (strobe) begin
            state_d = dec_state;
            up_d    = want_up && !miss;
            down_d  = want_down && !miss;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            decide_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            up_q     <= up_d;
            down_q   <= down_d;
            decide_q <= decide_d;
        end
    end

    assign up     = up_q;
    assign down   = down_q;
    assign state  = state_q;
    assign decide = decide_q;

endmodule

// File: tb/tb_paddle_ai.sv
// Scoreboard bench for paddle_ai: stimulus pushes predicted decisions, a monitor pops them on each decide pulse.
module tb_paddle_ai;

    localparam logic [7:0] MISS_T = 8'd2;
    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] ball_y;
    logic [1:0] ball_direction;
    logic [9:0] paddle_y;
    logic       up, down, decide;
    logic [1:0] state;

    paddle_ai #(.MISS_THRESH(MISS_T)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ball_y(ball_y),
        .ball_direction(ball_direction), .paddle_y(paddle_y),
        .up(up), .down(down), .state(state), .decide(decide)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [1:0] st;
        logic       up;
        logic       dn;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    bit   hold_chk = 1'b0;
    logic [1:0] last_st = 2'd0;
    logic last_up = 1'b0;
    logic last_dn = 1'b0;
    int   t0 = 0;
    int   win = 0;
    int   m_lfsr = 1;

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference behaviour: aim at the ball when it approaches (right side), else at screen centre.
    function automatic exp_t predict(int by, logic [1:0] dir, int py, int at);
        exp_t e;
        bit   appr;
        int   target;
        int   diff;
        appr   = (dir[0] == 1'b1);
        target = appr ? by : 240;
        diff   = target - (py + 20);
        e.at   = at;
        e.st   = appr ? 2'd1 : 2'd2;
        e.up   = (diff < -4) && (py != 0);
        e.dn   = (diff > 4) && (py < 440);
`ifdef PADDLE_AI_MISS_EN
        if (appr && m_lfsr < int'(MISS_T)) begin
            e.up = 1'b0;
            e.dn = 1'b0;
        end
        m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
`endif
        return e;
    endfunction

    task automatic applyStimulus(int by, logic [1:0] dir, int py);
        ball_y         = 10'(by);
        ball_direction = dir;
        paddle_y       = 10'(py);
        win++;
        sb_q.push_back(predict(by, dir, py, t0 + WIN * win));
        repeat (WIN) @(negedge clk);
    endtask

    // Monitor: pops an expectation on every decide pulse, otherwise checks outputs hold.
    always @(negedge clk) begin
        if (reset || !enable) begin
            last_st = 2'd0;
            last_up = 1'b0;
            last_dn = 1'b0;
        end
        if (!reset) begin
            if (decide === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_decide", 32'(decide), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("decide_cycle", cyc, mon_e.at);
                    checkOutput("state", 32'(state), 32'(mon_e.st));
                    checkOutput("up", 32'(up), 32'(mon_e.up));
                    checkOutput("down", 32'(down), 32'(mon_e.dn));
                    last_st = mon_e.st;
                    last_up = mon_e.up;
                    last_dn = mon_e.dn;
                end
            end else if (hold_chk) begin
                checkOutput("hold_state", 32'(state), 32'(last_st));
                checkOutput("hold_up", 32'(up), 32'(last_up));
                checkOutput("hold_down", 32'(down), 32'(last_dn));
            end
            checkOutput("exclusive", 32'(up & down), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int py;
        int by;
        int off;
        logic [1:0] r_dir;

        reset          = 1'b1;
        enable         = 1'b0;
        ball_y         = '0;
        ball_direction = '0;
        paddle_y       = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_up", 32'(up), 32'd0);
        checkOutput("reset_down", 32'(down), 32'd0);
        checkOutput("reset_decide", 32'(decide), 32'd0);
        reset = 1'b0;

        $display("[TB] idle with enable low for 100 clocks");
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checkOutput("idle_state", 32'(state), 32'd0);
            checkOutput("idle_outputs", 32'({up, down}), 32'd0);
        end

        t0       = cyc;
        enable   = 1'b1;
        hold_chk = 1'b1;
        applyStimulus(300, 2'b01, 100);
        applyStimulus(124, 2'b01, 100);
        applyStimulus(125, 2'b01, 100);
        applyStimulus(0,   2'b00, 0);
        applyStimulus(0,   2'b01, 0);
        applyStimulus(479, 2'b01, 440);
        applyStimulus(76,  2'b11, 100);
        applyStimulus(75,  2'b11, 100);
        applyStimulus(200, 2'b10, 220);

        $display("[TB] randomized windows");
        for (int i = 0; i < 24; i++) begin
            py    = (i % 6 == 0) ? 0 : int'($urandom_range(0, 470));
            r_dir = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                off = int'($urandom_range(0, 12)) - 6;
                by  = py + 20 + off;
                if (by < 0) by = 0;
                if (by > 479) by = 479;
            end else begin
                by = int'($urandom_range(0, 479));
            end
            applyStimulus(by, r_dir, py);
        end

        $display("[TB] enable dropped on the strobe cycle");
        applyStimulus(300, 2'b01, 100);
        repeat (WIN - 1) @(negedge clk);
        hold_chk = 1'b0;
        enable   = 1'b0;
        @(negedge clk);
        checkOutput("drop_state", 32'(state), 32'd0);
        checkOutput("drop_down", 32'(down), 32'd0);
        checkOutput("drop_decide", 32'(decide), 32'd0);

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("post_drop_state", 32'(state), 32'd0);
            checkOutput("post_drop_outputs", 32'({up, down}), 32'd0);
        end

        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
